buf_sync_debounce: RTL and testbench

- Input-conditioning stage directly upstream of the BUF gate.
- Takes a raw, asynchronous, possibly bouncing single-bit signal and synchronises it into the clock domain. Debounces it and presents a clean registered level on Y, which drives the buffer's A input.
- Also emits one-cycle rise/fall pulses for downstream control logic.

---
 rtl/buf_sync_debounce_if.sv | 28 ++
 rtl/buf_sync_debounce.sv | 137 +++++++++++++
 tb/tb_buf_sync_debounce.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/buf_sync_debounce_if.sv
// Signal bundle between the input-conditioning stage and its consumers.
// The master drives the raw input and enable. The slave returns the conditioned level, pulses and busy.
interface buf_sync_debounce_if;
  logic A;
  logic en;
  logic Y;
  logic rise;
  logic fall;
  logic busy;

  modport master (
    output A,
    output en,
    input  Y,
    input  rise,
    input  fall,
    input  busy
  );

  modport slave (
    input  A,
    input  en,
    output Y,
    output rise,
    output fall,
    output busy
  );
endinterface

// File: rtl/buf_sync_debounce.sv
// Synchronises a raw asynchronous input, debounces it and drives a clean level toward the BUF gate.
// Also produces one-cycle rise/fall pulses and a busy flag while a new level is being qualified.
module buf_sync_debounce #(
  parameter int  SYNC_STAGES     = 2,
  parameter int  DEBOUNCE_CYCLES = 4,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  buf_sync_debounce_if.slave bus
);

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("buf_sync_debounce: SYNC_STAGES must be 2 or more");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
    $error("buf_sync_debounce: DEBOUNCE_CYCLES must be 1 or more");
  end

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   a_s;
  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   y_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   busy_q;

  // Oldest synchroniser stage is the only one the FSM may look at.
  assign a_s   = sync_q[SYNC_STAGES-1];
  assign cnt_d = cnt_q + CNT_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      y_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.A};
      rise_q <= 1'b0;
      fall_q <= 1'b0;

      case (state_q)
        STABLE_LO: begin
          if (bus.en && a_s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_q <= STABLE_HI;
              y_q     <= 1'b1;
              rise_q  <= 1'b1;
              cnt_q   <= '0;
            end else begin
              state_q <= PEND_HI;
              busy_q  <= 1'b1;
              cnt_q   <= CNT_ONE;
            end
          end
        end

        PEND_HI: begin
          // A dropped input or a disable rejects the candidate without a pulse.
          if (!bus.en || !a_s) begin
            state_q <= STABLE_LO;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_d == CNT_MAX) begin
            state_q <= STABLE_HI;
            y_q     <= 1'b1;
            rise_q  <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        STABLE_HI: begin
          if (bus.en && !a_s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_q <= STABLE_LO;
              y_q     <= 1'b0;
              fall_q  <= 1'b1;
              cnt_q   <= '0;
            end else begin
              state_q <= PEND_LO;
              busy_q  <= 1'b1;
              cnt_q   <= CNT_ONE;
            end
          end
        end

        PEND_LO: begin
          if (!bus.en || a_s) begin
            state_q <= STABLE_HI;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_d == CNT_MAX) begin
            state_q <= STABLE_LO;
            y_q     <= 1'b0;
            fall_q  <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        default: begin
          state_q <= STABLE_LO;
          y_q     <= 1'b0;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.Y    = y_q;
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_buf_sync_debounce.sv
// Bench for buf_sync_debounce: default instance plus a DEBOUNCE_CYCLES=1 / SYNC_STAGES=3 instance on shared stimulus.
// A run-length reference model predicts every output after every clock edge.
module tb_buf_sync_debounce;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_req = 1'b0;

  always #5 clk = ~clk;

  buf_sync_debounce_if ifc0 ();
  buf_sync_debounce_if ifc1 ();

  buf_sync_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc0)
  );

  buf_sync_debounce #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: instance 0 = defaults, instance 1 = S3/D1.
  int         m_S [2] = '{2, 3};
  int         m_D [2] = '{4, 1};
  logic [7:0] m_hist [2];
  int         m_run [2];
  logic       m_y [2];
  logic       m_rise [2];
  logic       m_fall [2];
  logic       m_busy [2];
  logic [7:0] ahist;
  logic       track_en = 1'b0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_hist[i] = '0;
      m_run[i]  = 0;
      m_y[i]    = 1'b0;
      m_rise[i] = 1'b0;
      m_fall[i] = 1'b0;
      m_busy[i] = 1'b0;
    end
    ahist = '0;
  endtask

  // The FSM sees A as it was S edges ago; Y flips after D consecutive enabled edges of disagreement.
  task automatic model_edge(input int i, input logic a, input logic e);
    logic as;
    as        = m_hist[i][m_S[i]-1];
    m_hist[i] = {m_hist[i][6:0], a};
    m_rise[i] = 1'b0;
    m_fall[i] = 1'b0;
    if (e && (as != m_y[i])) begin
      m_run[i]++;
      if (m_run[i] == m_D[i]) begin
        m_y[i]   = ~m_y[i];
        m_rise[i] = m_y[i];
        m_fall[i] = ~m_y[i];
        m_run[i] = 0;
      end
    end else begin
      m_run[i] = 0;
    end
    m_busy[i] = (m_run[i] != 0);
  endtask

  task automatic cyc(input logic a, input logic e);
    @(negedge clk);
    rst_n   = rst_req;
    ifc0.A  = a;
    ifc0.en = e;
    ifc1.A  = a;
    ifc1.en = e;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      model_edge(0, a, e);
      model_edge(1, a, e);
      ahist = {ahist[6:0], a};
    end
    #1;
    chk("d0_Y",    ifc0.Y,    m_y[0]);
    chk("d0_rise", ifc0.rise, m_rise[0]);
    chk("d0_fall", ifc0.fall, m_fall[0]);
    chk("d0_busy", ifc0.busy, m_busy[0]);
    chk("d1_Y",    ifc1.Y,    m_y[1]);
    chk("d1_rise", ifc1.rise, m_rise[1]);
    chk("d1_fall", ifc1.fall, m_fall[1]);
    chk("d1_busy", ifc1.busy, m_busy[1]);
    if (track_en && rst_n) chk("d1_track_A_delay4", ifc1.Y, ahist[3]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_busy;
    int   hold;
    logic ra;
    logic re;

    ifc0.A = 1'b0; ifc0.en = 1'b1;
    ifc1.A = 1'b0; ifc1.en = 1'b1;
    model_reset();

    // Reset held with A=1, then release and count edges to the rise.
    rst_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b1);
      chk("rst_Y",    ifc0.Y,    1'b0);
      chk("rst_rise", ifc0.rise, 1'b0);
      chk("rst_busy", ifc0.busy, 1'b0);
    end
    rst_req = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      cyc(1'b1, 1'b1);
      if (k >= 3 && k <= 5) chk("lat_busy_hi", ifc0.busy, 1'b1);
      if (k < 6)  chk("lat_Y_lo", ifc0.Y, 1'b0);
      if (k == 6) begin
        chk("lat_Y_hi", ifc0.Y,    1'b1);
        chk("lat_rise", ifc0.rise, 1'b1);
      end
      if (k == 7) chk("lat_rise_end", ifc0.rise, 1'b0);
    end

    // Clean fall.
    for (int k = 1; k <= 7; k++) begin
      cyc(1'b0, 1'b1);
      if (k < 6) chk("fall_Y_hold", ifc0.Y, 1'b1);
      if (k == 6) begin
        chk("fall_Y_lo", ifc0.Y,    1'b0);
        chk("fall_puls", ifc0.fall, 1'b1);
      end
      if (k == 7) chk("fall_puls_end", ifc0.fall, 1'b0);
    end

    // Bounce, then stable 1.
    cyc(1'b1, 1'b1); cyc(1'b0, 1'b1); cyc(1'b1, 1'b1); cyc(1'b0, 1'b1);
    chk("bounce_no_rise", ifc0.rise, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1, 1'b1);
      if (k < 6) chk("bounce_Y_lo", ifc0.Y, 1'b0);
      if (k == 6) begin
        chk("bounce_Y_hi", ifc0.Y,    1'b1);
        chk("bounce_rise", ifc0.rise, 1'b1);
      end
    end

    // Back to 0, then a 3-cycle glitch.
    for (int k = 0; k < 8; k++) cyc(1'b0, 1'b1);
    seen_busy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b1);
      seen_busy |= ifc0.busy;
    end
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 1'b1);
      seen_busy |= ifc0.busy;
      chk("glitch_Y",    ifc0.Y,    1'b0);
      chk("glitch_rise", ifc0.rise, 1'b0);
    end
    chk("glitch_busy_seen", seen_busy, 1'b1);

    // Disable while pending at cnt=3, then re-enable.
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b1);
    chk("en_busy_pend", ifc0.busy, 1'b1);
    cyc(1'b1, 1'b0);
    chk("en_busy_clr", ifc0.busy, 1'b0);
    chk("en_Y_hold",   ifc0.Y,    1'b0);
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b1, 1'b1);
      chk("en_requal_Y", ifc0.Y, (k == 4));
    end

    // Random runs with occasional disable and reset.
    hold = 0;
    ra   = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (hold == 0) begin
        ra   = $urandom_range(0, 1);
        hold = $urandom_range(1, 7);
      end
      hold--;
      re      = ($urandom_range(0, 9) != 0);
      rst_req = ($urandom_range(0, 99) != 0);
      cyc(ra, re);
    end
    rst_req = 1'b1;

    // Always-enabled random input: the D=1 instance must follow A four edges late.
    for (int k = 0; k < 4; k++) cyc($urandom_range(0, 1), 1'b1);
    track_en = 1'b1;
    for (int k = 0; k < 200; k++) cyc($urandom_range(0, 1), 1'b1);
    track_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
